vga_timing_receiver: RTL and testbench

Recovers pixel coordinates from an incoming VGA hsync/vsync pair and the pixel-rate enable (`pixel_tick`, one `clk` cycle in four). It is the receiving counterpart of the controller's timing generator. It sits at the front of the convolution capture path and tells the line buffers which pixel is current, whether it is in the active area, and whether the input timing is trusted.

---
 rtl/vga_timing_pkg.sv | 38 +++
 rtl/vga_sync_edge.sv | 40 ++++
 rtl/vga_timing_receiver.sv | 208 ++++++++++++++++++++
 tb/tb_vga_timing_receiver.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared definitions for the VGA timing receiver: 640x480@60 default timing constants,
// helpers that derive line/frame totals and sync-to-active offsets, and the lock FSM state
// type. No ports (package).
package vga_timing_pkg;

    localparam int unsigned DEF_H_ACTIVE    = 640;
    localparam int unsigned DEF_H_FP        = 16;
    localparam int unsigned DEF_H_SYNC      = 96;
    localparam int unsigned DEF_H_BP        = 48;
    localparam int unsigned DEF_V_ACTIVE    = 480;
    localparam int unsigned DEF_V_FP        = 10;
    localparam int unsigned DEF_V_SYNC      = 2;
    localparam int unsigned DEF_V_BP        = 33;
    localparam int unsigned DEF_SYNC_POL    = 0;
    localparam int unsigned DEF_LOCK_FRAMES = 2;

    // Width of the pixel/line counters and of the x/y outputs.
    localparam int unsigned CNT_W = 10;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

    // Total ticks per line (or lines per frame).
    function automatic int unsigned calc_total(input int unsigned act, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    // Counter value of the first active pixel/line, counted from the sync assertion edge.
    function automatic int unsigned calc_ofs(input int unsigned sync, input int unsigned bp);
        return sync + bp;
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge
// Polarity normalisation and assertion-edge detection for one sync signal.
// Ports:
//   clk, reset   - system clock, synchronous active-high reset
//   en           - sample enable; the previous-level register only moves when en=1
//   sync_in      - raw sync input (synchronous to clk)
//   assert_edge  - combinational: en=1, sync asserted now, and deasserted at the last sample
module vga_sync_edge #(
    parameter bit SYNC_POL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic sync_in,
    output logic assert_edge
);

    logic level;
    logic prev_q, prev_d;

    assign level = (sync_in == SYNC_POL);

    always_comb begin
        prev_d = prev_q;
        if (en) begin
            prev_d = level;
        end
    end

    assign assert_edge = en & level & ~prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/vga_timing_receiver.sv
// vga_timing_receiver
// Recovers pixel coordinates from incoming hsync/vsync, checks line/frame lengths and
// declares lock after LOCK_FRAMES consecutive clean frames.
// Ports:
//   clk, reset     - system clock, synchronous active-high reset
//   pixel_tick     - pixel enable; nothing moves in cycles where it is 0
//   hsync_in       - horizontal sync (polarity set by SYNC_POL)
//   vsync_in       - vertical sync (polarity set by SYNC_POL)
//   x, y           - active-area column/row (hold outside the active area)
//   active         - current pixel is in the active area and timing is locked
//   line_start     - one-clk pulse per hsync assertion edge
//   frame_start    - one-clk pulse per vsync assertion edge
//   locked         - timing verified
//   sync_err       - one-clk pulse per timing violation
module vga_timing_receiver
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned H_FP        = DEF_H_FP,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BP        = DEF_H_BP,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned V_FP        = DEF_V_FP,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BP        = DEF_V_BP,
    parameter int unsigned SYNC_POL    = DEF_SYNC_POL,
    parameter int unsigned LOCK_FRAMES = DEF_LOCK_FRAMES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pixel_tick,
    input  logic             hsync_in,
    input  logic             vsync_in,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             active,
    output logic             line_start,
    output logic             frame_start,
    output logic             locked,
    output logic             sync_err
);

    localparam int unsigned H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned H_OFS   = calc_ofs(H_SYNC, H_BP);
    localparam int unsigned V_OFS   = calc_ofs(V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_BEG  = CNT_W'(H_OFS);
    localparam logic [CNT_W-1:0] V_BEG  = CNT_W'(V_OFS);
    localparam logic [CNT_W-1:0] H_END  = CNT_W'(H_OFS + H_ACTIVE);
    localparam logic [CNT_W-1:0] V_END  = CNT_W'(V_OFS + V_ACTIVE);

    // good_cnt counts 0..LOCK_FRAMES-1; the frame that would reach LOCK_FRAMES locks instead.
    localparam int unsigned        GOOD_W    = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES) : 1;
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_FRAMES - 1);

    logic h_edge, v_edge;
    logic h_err, v_err, viol;
    logic in_h, in_v;

    logic [CNT_W-1:0]  h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0]  v_cnt_q, v_cnt_d;
    logic [CNT_W-1:0]  x_q, x_d;
    logic [CNT_W-1:0]  y_q, y_d;
    lock_state_t       state_q, state_d;
    logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
    logic              active_q, active_d;
    logic              line_start_q, line_start_d;
    logic              frame_start_q, frame_start_d;
    logic              locked_q, locked_d;
    logic              sync_err_q, sync_err_d;

    vga_sync_edge #(
        .SYNC_POL (SYNC_POL != 0)
    ) u_hsync (
        .clk         (clk),
        .reset       (reset),
        .en          (pixel_tick),
        .sync_in     (hsync_in),
        .assert_edge (h_edge)
    );

    // vsync is only looked at on hsync edges, so its edge is line-aligned.
    vga_sync_edge #(
        .SYNC_POL (SYNC_POL != 0)
    ) u_vsync (
        .clk         (clk),
        .reset       (reset),
        .en          (h_edge),
        .sync_in     (vsync_in),
        .assert_edge (v_edge)
    );

    // Counters and length checks. Counters saturate at TOTAL-1 instead of wrapping.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        h_err   = 1'b0;
        v_err   = 1'b0;
        if (pixel_tick) begin
            if (h_edge) begin
                h_err   = (h_cnt_q != H_LAST);
                h_cnt_d = '0;
                if (v_edge) begin
                    v_err   = (v_cnt_q != V_LAST);
                    v_cnt_d = '0;
                end else if (v_cnt_q == V_LAST) begin
                    v_err = 1'b1;
                end else begin
                    v_cnt_d = v_cnt_q + 10'd1;
                end
            end else if (h_cnt_q == H_LAST) begin
                h_err = 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    assign viol = h_err | v_err;

    // Lock FSM. A violation always wins over a good-frame completion on the same tick.
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        unique case (state_q)
            SEARCH: begin
                if (v_edge) begin
                    state_d    = VERIFY;
                    good_cnt_d = '0;
                end
            end
            VERIFY: begin
                if (viol) begin
                    state_d = SEARCH;
                end else if (v_edge) begin
                    if (good_cnt_q == GOOD_LAST) begin
                        state_d = LOCKED;
                    end else begin
                        good_cnt_d = good_cnt_q + 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (viol) begin
                    state_d = SEARCH;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    // Outputs reflect the post-tick counters so they line up with the sample just taken.
    always_comb begin
        in_h          = (h_cnt_d >= H_BEG) && (h_cnt_d < H_END);
        in_v          = (v_cnt_d >= V_BEG) && (v_cnt_d < V_END);
        x_d           = x_q;
        y_d           = y_q;
        if (in_h && in_v) begin
            x_d = h_cnt_d - H_BEG;
            y_d = v_cnt_d - V_BEG;
        end
        locked_d      = (state_d == LOCKED);
        active_d      = locked_d && in_h && in_v;
        line_start_d  = h_edge;
        frame_start_d = v_edge;
        sync_err_d    = viol;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            x_q           <= '0;
            y_q           <= '0;
            state_q       <= SEARCH;
            good_cnt_q    <= '0;
            active_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            x_q           <= x_d;
            y_q           <= y_d;
            state_q       <= state_d;
            good_cnt_q    <= good_cnt_d;
            active_q      <= active_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign active      = active_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_vga_timing_receiver.sv
// tb_vga_timing_receiver
// Bench for vga_timing_receiver using a reduced timing (15x11 ticks per frame) so that
// several frames fit in a short run. Two instances run side by side on the same stimulus:
// dut0 with active-low syncs and dut1 with active-high (inverted) syncs.
module tb_vga_timing_receiver;

    localparam int HA = 8, HFP = 2, HS = 3, HB = 2;
    localparam int VA = 6, VFP = 1, VS = 2, VB = 2;
    localparam int HT = HA + HFP + HS + HB;
    localparam int VT = VA + VFP + VS + VB;
    localparam int HO = HS + HB;
    localparam int VO = VS + VB;
    localparam int LOCK = 2;

    logic       clk = 1'b0;
    logic       reset, pixel_tick, hs_lvl, vs_lvl, hs_n, vs_n;
    logic [9:0] x0, y0, x1, y1;
    logic       active0, ls0, fs0, lk0, se0;
    logic       active1, ls1, fs1, lk1, se1;
    logic [24:0] obs0, obs1;

    int checks = 0;
    int errors = 0;

    // Golden generator position and current line length.
    int gen_h = 0, gen_v = 0, cur_len = HT;

    // Reference model state (specification-level: ticks since hsync, lines since vsync).
    int  m_h, m_v, m_good, m_phase;
    bit  m_hprev, m_vprev;
    logic [9:0] e_x, e_y;
    bit  e_active, e_ls, e_fs, e_locked, e_err;

    always #5 clk = ~clk;

    assign hs_n = ~hs_lvl;
    assign vs_n = ~vs_lvl;
    assign obs0 = {x0, y0, active0, ls0, fs0, lk0, se0};
    assign obs1 = {x1, y1, active1, ls1, fs1, lk1, se1};

    vga_timing_receiver #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(0), .LOCK_FRAMES(LOCK)
    ) dut0 (
        .clk(clk), .reset(reset), .pixel_tick(pixel_tick),
        .hsync_in(hs_n), .vsync_in(vs_n),
        .x(x0), .y(y0), .active(active0), .line_start(ls0), .frame_start(fs0),
        .locked(lk0), .sync_err(se0)
    );

    vga_timing_receiver #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1), .LOCK_FRAMES(LOCK)
    ) dut1 (
        .clk(clk), .reset(reset), .pixel_tick(pixel_tick),
        .hsync_in(hs_lvl), .vsync_in(vs_lvl),
        .x(x1), .y(y1), .active(active1), .line_start(ls1), .frame_start(fs1),
        .locked(lk1), .sync_err(se1)
    );

    // Predict the outputs that follow the coming clock edge from the inputs now applied.
    task automatic model_step();
        bit he, ve, bad;
        e_ls  = 1'b0;
        e_fs  = 1'b0;
        e_err = 1'b0;
        if (reset) begin
            m_h = 0; m_v = 0; m_good = 0; m_phase = 0; m_hprev = 0; m_vprev = 0;
            e_x = '0; e_y = '0; e_active = 1'b0; e_locked = 1'b0;
        end else if (pixel_tick) begin
            he = hs_lvl && !m_hprev;
            m_hprev = hs_lvl;
            ve = 1'b0;
            bad = 1'b0;
            if (he) begin
                ve = vs_lvl && !m_vprev;
                m_vprev = vs_lvl;
            end
            if (he) begin
                if (m_h != HT - 1) bad = 1'b1;
                m_h = 0;
                if (ve) begin
                    if (m_v != VT - 1) bad = 1'b1;
                    m_v = 0;
                end else if (m_v + 1 >= VT) bad = 1'b1;
                else m_v++;
            end else if (m_h + 1 >= HT) bad = 1'b1;
            else m_h++;
            if (m_phase == 0) begin
                if (ve) begin m_phase = 1; m_good = 0; end
            end else if (bad) begin
                m_phase = 0;
            end else if (m_phase == 1 && ve) begin
                m_good++;
                if (m_good >= LOCK) m_phase = 2;
            end
            e_locked = (m_phase == 2);
            if (m_h >= HO && m_h < HO + HA && m_v >= VO && m_v < VO + VA) begin
                e_x = 10'(m_h - HO);
                e_y = 10'(m_v - VO);
                e_active = e_locked;
            end else begin
                e_active = 1'b0;
            end
            e_ls = he; e_fs = ve; e_err = bad;
        end
    endtask

    // One clk cycle of stimulus; both instances are scored against the model afterwards.
    task automatic cycle(input bit rst, input bit tk, input bit hs, input bit vs);
        logic [24:0] exp_v;
        reset = rst; pixel_tick = tk; hs_lvl = hs; vs_lvl = vs;
        model_step();
        exp_v = {e_x, e_y, e_active, e_ls, e_fs, e_locked, e_err};
        @(negedge clk);
        checks++;
        if (obs0 !== exp_v) begin
            errors++;
            $display("FAIL model_pol0 t=%0t got=%h exp=%h", $time, obs0, exp_v);
        end
        checks++;
        if (obs1 !== exp_v) begin
            errors++;
            $display("FAIL model_pol1 t=%0t got=%h exp=%h", $time, obs1, exp_v);
        end
    endtask

    // Random idle gap (syncs toggling meaninglessly), then one tick with the given levels.
    task automatic one_tick(input bit hs, input bit vs);
        int idle = $urandom_range(0, 3);
        for (int i = 0; i < idle; i++) cycle(1'b0, 1'b0, 1'($urandom), 1'($urandom));
        cycle(1'b0, 1'b1, hs, vs);
    endtask

    task automatic next_tick(input bit hs_en);
        one_tick(hs_en && gen_h < HS, gen_v < VS);
        gen_h++;
        if (gen_h >= cur_len) begin
            gen_h = 0;
            gen_v = (gen_v + 1) % VT;
            cur_len = HT;
        end
    endtask

    task automatic wait_relock(input string name, input int max_frames);
        bit ok = 1'b0;
        for (int t = 0; t < max_frames * HT * VT && !ok; t++) begin
            next_tick(1'b1);
            if (lk0 === 1'b1) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s got locked=%b required locked=1", name, lk0);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
        checks++;
        if (obs0 !== 25'd0) begin
            errors++;
            $display("FAIL reset_pol0 got=%h required=0", obs0);
        end
        checks++;
        if (obs1 !== 25'd0) begin
            errors++;
            $display("FAIL reset_pol1 got=%h required=0", obs1);
        end
        gen_h = 0; gen_v = 0; cur_len = HT;
    endtask

    task automatic test_nominal();
        int fs_n = 0, lock_at = -1, act_cnt, h0, v0;
        bit prev_lk = 1'b0, lock_fs = 1'b0, seen, in_rng;
        for (int f = 0; f < 4; f++) begin
            act_cnt = 0;
            seen = 1'b0;
            for (int t = 0; t < HT * VT; t++) begin
                h0 = gen_h; v0 = gen_v;
                next_tick(1'b1);
                if (fs0 === 1'b1) fs_n++;
                if (lk0 === 1'b1 && !prev_lk) begin lock_at = fs_n; lock_fs = fs0; end
                prev_lk = lk0;
                if (active0 === 1'b1) act_cnt++;
                if (f >= 2) begin
                    in_rng = h0 >= HO && h0 < HO + HA && v0 >= VO && v0 < VO + VA;
                    checks++;
                    if (active0 !== in_rng) begin
                        errors++;
                        $display("FAIL active_window h=%0d v=%0d got=%b required=%b",
                                 h0, v0, active0, in_rng);
                    end
                    if (in_rng && !seen) begin
                        seen = 1'b1;
                        checks++;
                        if (x0 !== 10'd0 || y0 !== 10'd0 || h0 != HO || v0 != VO) begin
                            errors++;
                            $display("FAIL first_active got x=%0d y=%0d at h=%0d v=%0d",
                                     x0, y0, h0, v0);
                        end
                    end
                    if (h0 == HO + HA - 1 && v0 == VO + VA - 1) begin
                        checks++;
                        if (x0 !== 10'(HA - 1) || y0 !== 10'(VA - 1) || active0 !== 1'b1) begin
                            errors++;
                            $display("FAIL last_active got x=%0d y=%0d act=%b required %0d %0d 1",
                                     x0, y0, active0, HA - 1, VA - 1);
                        end
                    end
                end
            end
            if (f >= 2) begin
                checks++;
                if (act_cnt != HA * VA) begin
                    errors++;
                    $display("FAIL active_count got=%0d required=%0d", act_cnt, HA * VA);
                end
            end
        end
        checks++;
        if (lock_at != 3 || !lock_fs) begin
            errors++;
            $display("FAIL lock_edge got vsync_edge=%0d with_fs=%b required 3 1",
                     lock_at, lock_fs);
        end
    endtask

    task automatic test_short_line();
        int line = $urandom_range(1, VT - 2);
        int fs_n = 0;
        bit ok = 1'b0;
        while (!(gen_v == line && gen_h == 0)) next_tick(1'b1);
        cur_len = HT - 1;
        while (!(gen_v == line + 1 && gen_h == 0)) next_tick(1'b1);
        checks++;
        if (lk0 !== 1'b1) begin
            errors++;
            $display("FAIL short_prelock got=%b required=1", lk0);
        end
        next_tick(1'b1);
        checks++;
        if ({se0, lk0, active0} !== 3'b100) begin
            errors++;
            $display("FAIL short_line got err/lock/act=%b%b%b required=100", se0, lk0, active0);
        end
        for (int t = 0; t < 5 * HT * VT && !ok; t++) begin
            next_tick(1'b1);
            if (fs0 === 1'b1) fs_n++;
            if (lk0 === 1'b1) ok = 1'b1;
        end
        checks++;
        if (!ok || fs_n != 3) begin
            errors++;
            $display("FAIL short_relock got locked=%b vsync_edges=%0d required 1 3", ok, fs_n);
        end
    endtask

    task automatic test_missing_hsync();
        int first_err = -1;
        logic [9:0] sx = '0;
        while (gen_h != 1) next_tick(1'b1);
        checks++;
        if (lk0 !== 1'b1) begin
            errors++;
            $display("FAIL miss_prelock got=%b required=1", lk0);
        end
        for (int j = 1; j <= HT + 2; j++) begin
            next_tick(1'b0);
            if (se0 === 1'b1 && first_err < 0) first_err = j;
            if (j == HT - 1) sx = x0;
        end
        checks++;
        if (first_err != HT || lk0 !== 1'b0 || x0 !== sx) begin
            errors++;
            $display("FAIL missing_hsync got first_err=%0d locked=%b x=%0d required %0d 0 %0d",
                     first_err, lk0, x0, HT, sx);
        end
        wait_relock("miss_relock", 6);
    endtask

    task automatic test_gap();
        logic [9:0] sx, sy;
        while (!(gen_v == VO + 2 && gen_h == HO + 3)) next_tick(1'b1);
        sx = x0; sy = y0;
        for (int i = 0; i < 100; i++) begin
            cycle(1'b0, 1'b0, 1'($urandom), 1'($urandom));
            checks++;
            if (x0 !== sx || y0 !== sy || {ls0, fs0, se0} !== 3'b000) begin
                errors++;
                $display("FAIL tick_gap got x=%0d y=%0d pulses=%b%b%b required %0d %0d 000",
                         x0, y0, ls0, fs0, se0, sx, sy);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = $urandom_range(20, 120);
        for (int i = 0; i < n; i++) next_tick(1'b1);
        cycle(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
        checks++;
        if (obs0 !== 25'd0 || obs1 !== 25'd0) begin
            errors++;
            $display("FAIL reset_mid got=%h/%h required=0", obs0, obs1);
        end
        gen_h = 0; gen_v = 0; cur_len = HT;
        wait_relock("reset_relock", 6);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_short_line();
        test_missing_hsync();
        test_gap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
